// File: rtl/collision_scan_ctrl_pkg.sv
// Shared game definitions: scan FSM states, hit-box size and playfield defaults.
package collision_scan_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SCAN   = 2'd1,
      REPORT = 2'd2
   } scan_state_t;

   localparam int HIT_BOX       = 20;
   localparam int DEF_ROWS      = 4;
   localparam int DEF_COLS      = 8;
   localparam int DEF_COL_PITCH = 30;
   localparam int DEF_ROW_PITCH = 25;

endpackage

// File: rtl/collision_scan_ctrl_detector.sv
// Inclusive bounding-box test of one bullet against one alien's hit box.
module collision_detector
   import collision_scan_ctrl_pkg::*;
(
   input  logic       alive,
   input  logic [9:0] target_x,
   input  logic [8:0] target_y,
   input  logic [9:0] bullet_x,
   input  logic [8:0] bullet_y,
   output logic       hit
);

   logic [10:0] tx, bx;
   logic [9:0]  ty, by;

   // Widened by one bit so the far edge (target + HIT_BOX) never wraps.
   always_comb begin
      tx  = {1'b0, target_x};
      bx  = {1'b0, bullet_x};
      ty  = {1'b0, target_y};
      by  = {1'b0, bullet_y};
      hit = alive
            && (bx >= tx) && (bx <= tx + 11'(HIT_BOX))
            && (by >= ty) && (by <= ty + 10'(HIT_BOX));
   end

endmodule

// File: rtl/collision_scan_ctrl.sv
// Per-frame sequential scan of the alien fleet for a bullet hit, one alien per cycle,
// against a snapshot of bullet, fleet and alive state taken when the scan starts.
module collision_scan_ctrl
   import collision_scan_ctrl_pkg::*;
#(
   parameter int ROWS      = DEF_ROWS,
   parameter int COLS      = DEF_COLS,
   parameter int COL_PITCH = DEF_COL_PITCH,
   parameter int ROW_PITCH = DEF_ROW_PITCH
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           frame_tick,
   input  logic                           bullet_active,
   input  logic [9:0]                     bullet_x,
   input  logic [8:0]                     bullet_y,
   input  logic [9:0]                     fleet_x,
   input  logic [8:0]                     fleet_y,
   input  logic [ROWS*COLS-1:0]           alien_alive,
   output logic                           busy,
   output logic                           kill_valid,
   output logic [$clog2(ROWS*COLS)-1:0]   kill_index,
   output logic                           bullet_consume,
   output logic                           scan_done
);

   localparam int N  = ROWS * COLS;
   localparam int IW = $clog2(N);
   localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
   localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

   scan_state_t   state_q, state_d;
   logic [IW-1:0] idx_q;
   logic [RW-1:0] row_q;
   logic [CW-1:0] col_q;
   logic [9:0]    snap_bx, snap_fx;
   logic [8:0]    snap_by, snap_fy;
   logic [N-1:0]  snap_alive;
   logic          hit_q;
   logic          idle_done_q;

   logic          start;
   logic          hit;
   logic [9:0]    target_x;
   logic [8:0]    target_y;

   assign target_x = snap_fx + 10'(col_q * COL_PITCH);
   assign target_y = snap_fy + 9'(row_q * ROW_PITCH);

   collision_detector u_det (
      .alive    (snap_alive[idx_q]),
      .target_x (target_x),
      .target_y (target_y),
      .bullet_x (snap_bx),
      .bullet_y (snap_by),
      .hit      (hit)
   );

   always_comb begin
      state_d        = state_q;
      start          = 1'b0;
      busy           = (state_q != IDLE);
      kill_valid     = (state_q == REPORT) && hit_q;
      bullet_consume = (state_q == REPORT) && hit_q;
      kill_index     = '0;
      scan_done      = (state_q == REPORT) || idle_done_q;
      if (kill_valid)
         kill_index = idx_q;
      unique case (state_q)
         IDLE: begin
            if (frame_tick && bullet_active) begin
               start   = 1'b1;
               state_d = SCAN;
            end
         end
         SCAN: begin
            if (hit || (idx_q == IW'(N - 1)))
               state_d = REPORT;
         end
         REPORT:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         row_q       <= '0;
         col_q       <= '0;
         snap_bx     <= '0;
         snap_by     <= '0;
         snap_fx     <= '0;
         snap_fy     <= '0;
         snap_alive  <= '0;
         hit_q       <= 1'b0;
         idle_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idle_done_q <= (state_q == IDLE) && frame_tick && !bullet_active;
         if (start) begin
            idx_q      <= '0;
            row_q      <= '0;
            col_q      <= '0;
            snap_bx    <= bullet_x;
            snap_by    <= bullet_y;
            snap_fx    <= fleet_x;
            snap_fy    <= fleet_y;
            snap_alive <= alien_alive;
            hit_q      <= 1'b0;
         end else if (state_q == SCAN) begin
            // On a hit the index freezes so REPORT can present it.
            if (hit) begin
               hit_q <= 1'b1;
            end else begin
               idx_q <= idx_q + 1'b1;
               if (col_q == CW'(COLS - 1)) begin
                  col_q <= '0;
                  row_q <= row_q + 1'b1;
               end else begin
                  col_q <= col_q + 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_collision_scan_ctrl.sv
// Directed bench for collision_scan_ctrl with hand-computed hit indices and latencies.
module tb_collision_scan_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        frame_tick;
   logic        bullet_active;
   logic [9:0]  bullet_x;
   logic [8:0]  bullet_y;
   logic [9:0]  fleet_x;
   logic [8:0]  fleet_y;
   logic [31:0] alien_alive;
   logic        busy;
   logic        kill_valid;
   logic [4:0]  kill_index;
   logic        bullet_consume;
   logic        scan_done;

   int checks   = 0;
   int failures = 0;

   int done_cyc, done_cnt, kill_cyc, kill_idx, busy_cnt, busy_last, pair_bad;

   always #5 clk = ~clk;

   collision_scan_ctrl #(
      .ROWS      (4),
      .COLS      (8),
      .COL_PITCH (30),
      .ROW_PITCH (25)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .frame_tick     (frame_tick),
      .bullet_active  (bullet_active),
      .bullet_x       (bullet_x),
      .bullet_y       (bullet_y),
      .fleet_x        (fleet_x),
      .fleet_y        (fleet_y),
      .alien_alive    (alien_alive),
      .busy           (busy),
      .kill_valid     (kill_valid),
      .kill_index     (kill_index),
      .bullet_consume (bullet_consume),
      .scan_done      (scan_done)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic setup(input logic act, input int bx, input int by, input logic [31:0] alive);
      @(negedge clk);
      bullet_active = act;
      bullet_x      = 10'(bx);
      bullet_y      = 9'(by);
      fleet_x       = 10'd100;
      fleet_y       = 9'd50;
      alien_alive   = alive;
   endtask

   // Ticks, then samples 80 cycles at the falling edge; cycle 1 follows the tick edge.
   task automatic run_scan(input int tick2_at, input bit perturb);
      done_cyc = -1; done_cnt = 0; kill_cyc = -1; kill_idx = -1;
      busy_cnt = 0; busy_last = -1; pair_bad = 0;
      frame_tick = 1'b1;
      for (int c = 1; c <= 80; c++) begin
         @(negedge clk);
         frame_tick = 1'b0;
         if (scan_done) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = c;
         end
         if (kill_valid && kill_cyc < 0) begin
            kill_cyc = c;
            kill_idx = int'(kill_index);
         end
         if (busy) begin
            busy_cnt++;
            busy_last = c;
         end
         if (kill_valid !== bullet_consume) pair_bad++;
         if (c == tick2_at) frame_tick = 1'b1;
         if (perturb && c == 2) begin
            bullet_x    = 10'd0;
            bullet_y    = 9'd0;
            fleet_x     = 10'd500;
            alien_alive = '0;
         end
      end
   endtask

   initial begin
      reset = 1'b1; frame_tick = 1'b0; bullet_active = 1'b0;
      bullet_x = '0; bullet_y = '0; fleet_x = '0; fleet_y = '0; alien_alive = '0;
      repeat (2) @(negedge clk);
      chk("reset_busy", int'(busy), 0);
      chk("reset_done", int'(scan_done), 0);
      chk("reset_kill", int'(kill_valid), 0);
      reset = 1'b0;
      @(negedge clk);
      chk("release_no_pulse", int'(scan_done | kill_valid | bullet_consume), 0);

      // Hit at row 1 col 2 with inputs scrambled mid-scan
      setup(1'b1, 165, 80, 32'hFFFF_FFFF);
      run_scan(0, 1'b1);
      chk("hit10_kill_cyc", kill_cyc, 12);
      chk("hit10_kill_idx", kill_idx, 10);
      chk("hit10_done_cyc", done_cyc, 12);
      chk("hit10_done_cnt", done_cnt, 1);
      chk("hit10_busy_cnt", busy_cnt, 12);
      chk("hit10_busy_last", busy_last, 12);
      chk("hit10_consume", pair_bad, 0);

      // Same bullet with alien 10 dead: full miss
      setup(1'b1, 165, 80, 32'hFFFF_FBFF);
      run_scan(0, 1'b0);
      chk("miss_done_cyc", done_cyc, 33);
      chk("miss_kill", kill_cyc, -1);
      chk("miss_busy_cnt", busy_cnt, 33);

      // Far corner of alien 0's box
      setup(1'b1, 120, 70, 32'hFFFF_FFFF);
      run_scan(0, 1'b0);
      chk("edge0_kill_idx", kill_idx, 0);
      chk("edge0_done_cyc", done_cyc, 2);
      chk("edge0_kill_cyc", kill_cyc, 2);

      // One pixel past alien 0 (dead anyway), short of alien 1
      setup(1'b1, 121, 50, 32'hFFFF_FFFE);
      run_scan(0, 1'b0);
      chk("gap_kill", kill_cyc, -1);
      chk("gap_done_cyc", done_cyc, 33);

      // No bullet in flight
      setup(1'b0, 165, 80, 32'hFFFF_FFFF);
      run_scan(0, 1'b0);
      chk("nobullet_done_cyc", done_cyc, 1);
      chk("nobullet_done_cnt", done_cnt, 1);
      chk("nobullet_busy", busy_cnt, 0);
      chk("nobullet_kill", kill_cyc, -1);

      // Extra tick while busy must be dropped
      setup(1'b1, 165, 80, 32'hFFFF_FBFF);
      run_scan(5, 1'b0);
      chk("retick_done_cnt", done_cnt, 1);
      chk("retick_done_cyc", done_cyc, 33);
      chk("retick_busy_cnt", busy_cnt, 33);

      // Reset mid-scan at cycle 7
      setup(1'b1, 165, 80, 32'hFFFF_FFFF);
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      repeat (6) @(negedge clk);
      chk("pre_reset_busy", int'(busy), 1);
      reset = 1'b1;
      #1;
      chk("midreset_busy", int'(busy), 0);
      chk("midreset_done", int'(scan_done), 0);
      chk("midreset_kill", int'(kill_valid), 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("midreset_release", int'(busy | scan_done | kill_valid), 0);
      run_scan(0, 1'b0);
      chk("restart_kill_cyc", kill_cyc, 12);
      chk("restart_kill_idx", kill_idx, 10);

      // Reset during REPORT clears a live kill_index
      setup(1'b1, 165, 80, 32'hFFFF_FFFF);
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
      repeat (11) @(negedge clk);
      chk("report_kill_idx", int'(kill_index), 10);
      reset = 1'b1;
      #1;
      chk("report_reset_idx", int'(kill_index), 0);
      chk("report_reset_consume", int'(bullet_consume), 0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("report_release", int'(scan_done | kill_valid | busy), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
